// File: rtl/bsg_half_deserialize_unswap.sv
// Half-width beat pair collector that rebuilds one full-width word.
// The swap flag carried on the first beat selects which half it fills.
module bsg_half_deserialize_unswap #(
  parameter int width_p = 32
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p/2-1:0] half_i,
  input  logic               swap_i,
  output logic               ready_o,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  localparam int hw_lp = width_p / 2;

  typedef enum logic [1:0] {
    S_FIRST  = 2'd0,
    S_SECOND = 2'd1,
    S_FULL   = 2'd2
  } state_e;

  state_e             state_r, state_n;
  logic [hw_lp-1:0]   first_r;
  logic               swap_r;
  logic [width_p-1:0] data_r;
  logic               accept;
  logic               take_first;
  logic               take_second;

  // next state and handshake decode
  always_comb begin
    state_n     = state_r;
    ready_o     = 1'b1;
    take_first  = 1'b0;
    take_second = 1'b0;
    accept      = 1'b0;
    unique case (state_r)
      S_FIRST: begin
        accept     = v_i;
        take_first = v_i;
        if (v_i) state_n = S_SECOND;
      end
      S_SECOND: begin
        accept      = v_i;
        take_second = v_i;
        if (v_i) state_n = S_FULL;
      end
      S_FULL: begin
        ready_o    = yumi_i;
        accept     = v_i & yumi_i;
        take_first = v_i & yumi_i;
        if (yumi_i) state_n = v_i ? S_SECOND : S_FIRST;
      end
      default: state_n = S_FIRST;
    endcase
  end

  // state register
  always_ff @(posedge clk_i) begin
    if (reset_i) state_r <= S_FIRST;
    else         state_r <= state_n;
  end

  // hold the first half and its swap flag until the partner beat arrives
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      first_r <= '0;
      swap_r  <= 1'b0;
    end else if (take_first) begin
      first_r <= half_i;
      swap_r  <= swap_i;
    end
  end

  // assemble the output word on the second beat
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      data_r <= '0;
    end else if (take_second) begin
      data_r <= swap_r ? {first_r, half_i} : {half_i, first_r};
    end
  end

  assign v_o    = (state_r == S_FULL);
  assign data_o = data_r;

  yumi_needs_valid: assert property (
    @(posedge clk_i) disable iff (reset_i) !(yumi_i && !v_o)
  );

  logic unused_accept;
  assign unused_accept = accept;

endmodule

// File: tb/tb_bsg_half_deserialize_unswap.sv
// Directed table plus randomized scoreboard check
// for the half-beat deserializer.
module tb_bsg_half_deserialize_unswap;

  localparam int W  = 32;
  localparam int HW = W / 2;

  logic          clk_i = 1'b0;
  logic          reset_i;
  logic          v_i;
  logic [HW-1:0] half_i;
  logic          swap_i;
  logic          ready_o;
  logic          v_o;
  logic [W-1:0]  data_o;
  logic          yumi_i;

  int n_chk = 0;
  int n_fail = 0;

  bsg_half_deserialize_unswap #(.width_p(W)) dut (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .v_i     (v_i),
    .half_i  (half_i),
    .swap_i  (swap_i),
    .ready_o (ready_o),
    .v_o     (v_o),
    .data_o  (data_o),
    .yumi_i  (yumi_i)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic          rst;
    logic          v;
    logic [HW-1:0] half;
    logic          swap;
    logic          yumi;
    logic          exp_ready;
    logic          exp_v;
    logic          chk_data;
    logic [W-1:0]  exp_data;
  } vec_t;

  task automatic chk(input string name, input logic [W-1:0] act,
                     input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  vec_t vecs[$];

  task automatic add(input logic rst, input logic v,
                     input logic [HW-1:0] half, input logic swap,
                     input logic yumi, input logic er, input logic ev,
                     input logic cd, input logic [W-1:0] ed);
    vec_t t;
    t.rst = rst; t.v = v; t.half = half; t.swap = swap; t.yumi = yumi;
    t.exp_ready = er; t.exp_v = ev; t.chk_data = cd; t.exp_data = ed;
    vecs.push_back(t);
  endtask

  logic [HW-1:0] beat_h;
  logic          beat_s;
  logic          have_first;
  logic [W-1:0]  exp_q[$];
  logic          exp_rdy;
  logic          v_smp;
  int            beats;
  int            cycles;

  initial begin
    reset_i = 1'b1; v_i = 1'b0; half_i = '0; swap_i = 1'b0; yumi_i = 1'b0;

    repeat (3) @(posedge clk_i);
    #1;
    chk("reset_v", {31'd0, v_o}, 32'd0);
    chk("reset_ready", {31'd0, ready_o}, 32'd1);
    chk("reset_data", data_o, 32'd0);
    reset_i = 1'b0;

    //   rst v half      sw yumi rdy v  cd data
    add(0, 0, 16'h0000, 0, 0,   1,  0, 1, 32'h0);
    add(0, 1, 16'hBEEF, 0, 0,   1,  0, 0, 32'h0);
    add(0, 1, 16'hDEAD, 0, 0,   1,  1, 1, 32'hDEADBEEF);
    add(0, 0, 16'h0000, 0, 1,   1,  0, 0, 32'h0);
    add(0, 1, 16'hDEAD, 1, 0,   1,  0, 0, 32'h0);
    add(0, 0, 16'h0000, 0, 0,   1,  0, 0, 32'h0);
    add(0, 1, 16'hBEEF, 0, 0,   1,  1, 1, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++)
      add(0, 1, 16'h9999, 1, 0, 0,  1, 1, 32'hDEADBEEF);
    add(0, 1, 16'h1234, 0, 1,   1,  0, 0, 32'h0);
    add(0, 1, 16'h5678, 1, 0,   1,  1, 1, 32'h56781234);
    add(0, 1, 16'hAAAA, 1, 1,   1,  0, 0, 32'h0);
    add(1, 0, 16'h0000, 0, 0,   1,  0, 1, 32'h0);
    add(0, 1, 16'h1111, 0, 0,   1,  0, 0, 32'h0);
    add(0, 1, 16'h2222, 1, 0,   1,  1, 1, 32'h22221111);
    add(0, 0, 16'h0000, 0, 1,   1,  0, 0, 32'h0);

    foreach (vecs[i]) begin
      reset_i = vecs[i].rst;
      v_i     = vecs[i].v;
      half_i  = vecs[i].half;
      swap_i  = vecs[i].swap;
      yumi_i  = vecs[i].yumi;
      #1;
      chk($sformatf("vec%0d_ready", i), {31'd0, ready_o},
          {31'd0, vecs[i].exp_ready});
      @(posedge clk_i);
      #1;
      chk($sformatf("vec%0d_v", i), {31'd0, v_o}, {31'd0, vecs[i].exp_v});
      if (vecs[i].chk_data)
        chk($sformatf("vec%0d_data", i), data_o, vecs[i].exp_data);
    end

    reset_i = 1'b1; v_i = 1'b0; yumi_i = 1'b0;
    @(posedge clk_i);
    #1;
    reset_i = 1'b0;

    have_first = 1'b0;
    beats = 0;
    cycles = 0;
    exp_q.delete();
    while (beats < 1000 && cycles < 20000) begin
      cycles++;
      chk("rnd_v", {31'd0, v_o}, {31'd0, exp_q.size() != 0});
      v_smp  = v_o;
      v_i    = ($urandom_range(3) != 0);
      half_i = HW'($urandom);
      swap_i = $urandom_range(1);
      yumi_i = v_smp && ($urandom_range(2) != 0);
      #1;
      exp_rdy = (exp_q.size() == 0) || yumi_i;
      chk("rnd_ready", {31'd0, ready_o}, {31'd0, exp_rdy});
      if (v_smp && yumi_i) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL rnd_extra: got word %h expected none", data_o);
        end else begin
          chk("rnd_data", data_o, exp_q.pop_front());
        end
      end
      if (v_i && exp_rdy) begin
        beats++;
        if (!have_first) begin
          beat_h = half_i;
          beat_s = swap_i;
          have_first = 1'b1;
        end else begin
          exp_q.push_back(beat_s ? {beat_h, half_i} : {half_i, beat_h});
          have_first = 1'b0;
        end
      end
      @(posedge clk_i);
      #1;
    end
    chk("rnd_budget", {31'd0, beats >= 1000}, 32'd1);

    v_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      yumi_i = v_o;
      #1;
      if (v_o) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL drain_extra: got word %h expected none", data_o);
        end else begin
          chk("drain_data", data_o, exp_q.pop_front());
        end
      end
      @(posedge clk_i);
      #1;
    end
    yumi_i = 1'b0;
    chk("drain_empty", exp_q.size(), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
